// File: rtl/sipo_frame_rx_pkg.sv
// Shared types and helpers for the serial frame receiver: FSM encoding,
// line levels and the even-parity helper.
package sipo_frame_rx_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Callers zero-extend their word, so XOR over all bits equals XOR over WIDTH bits.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// WIDTH-bit LSB-first shift register: each enabled edge pushes sin in at the
// top, so after WIDTH shifts the first bit received sits in bit 0.
module sipo_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = {sin_i, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver with a one-entry valid/ready holding buffer.
// Define SIPO_FRAME_RX_PARITY_EN to include the even-parity bit and check.
module sipo_frame_rx
  import sipo_frame_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_en_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  input  logic             q_ready_i,
  output logic             frame_err_o,
  output logic             parity_err_o,
  output logic             overrun_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_data;
  logic             shift_en;
  logic             deliver;
  logic             frame_err_d, frame_err_q;
  logic             overrun_d, overrun_q;
  logic [WIDTH-1:0] q_d, q_q;
  logic             q_valid_d, q_valid_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
  logic             perr_d, perr_q;
  logic             parity_err_d, parity_err_q;
`endif

  sipo_shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (shift_en),
    .sin_i (sin_i),
    .data_o(shift_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SIPO_FRAME_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (bit_en_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sin_i == START_LEVEL) begin
            state_d = ST_DATA;
            cnt_d   = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
          end
        end
        ST_DATA: begin
          if (cnt_q == LAST_CNT) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef SIPO_FRAME_RX_PARITY_EN
        ST_PARITY: begin
          // The last data bit was shifted in on the previous strobe, so the word is complete here.
          perr_d  = (sin_i != even_parity(MAX_WIDTH'(shift_data)));
          state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          state_d = (sin_i == STOP_LEVEL) ? ST_IDLE : ST_WAIT_HIGH;
`ifdef SIPO_FRAME_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
        ST_WAIT_HIGH: begin
          if (sin_i == IDLE_LEVEL) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    shift_en     = 1'b0;
    deliver      = 1'b0;
    frame_err_d  = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (bit_en_i) begin
      case (state_q)
        ST_DATA: shift_en = 1'b1;
        ST_STOP: begin
          if (sin_i == STOP_LEVEL) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
            if (perr_q) begin
              parity_err_d = 1'b1;
            end else begin
              deliver = 1'b1;
            end
`else
            deliver = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A delivery into a full buffer only wins if the consumer frees the slot on the same edge.
  always_comb begin
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = 1'b0;
    if (deliver) begin
      if (!q_valid_q || q_ready_i) begin
        q_d       = shift_data;
        q_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (q_valid_q && q_ready_i) begin
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q          <= '0;
      q_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      q_q          <= q_d;
      q_valid_q    <= q_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef SIPO_FRAME_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign q_o         = q_q;
  assign q_valid_o   = q_valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Randomised self-checking bench for sipo_frame_rx (WIDTH=4, strobe every 4th clk),
// driven frame-by-frame against an outcome-level model of the holding buffer.
module tb_sipo_frame_rx;

  localparam int W = 4;

  typedef enum int {EV_NONE, EV_GOOD, EV_PERR, EV_FERR} ev_e;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b1;
  logic         bit_en = 1'b0;
  logic         sin = 1'b1;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;
  logic         q_valid, frame_err, parity_err, overrun;

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] expQ = '0;
  logic         expValid = 1'b0, expFerr = 1'b0, expPerr = 1'b0, expOvr = 1'b0;
  bit           checkEn = 1'b0;
  int           readyMode = 0;

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bit_en_i    (bit_en),
    .sin_i       (sin),
    .q_o         (q),
    .q_valid_o   (q_valid),
    .q_ready_i   (q_ready),
    .frame_err_o (frame_err),
    .parity_err_o(parity_err),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, required);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("q", 32'(q), 32'(expQ));
      checkOutput("q_valid", 32'(q_valid), 32'(expValid));
      checkOutput("frame_err", 32'(frame_err), 32'(expFerr));
      checkOutput("parity_err", 32'(parity_err), 32'(expPerr));
      checkOutput("overrun", 32'(overrun), 32'(expOvr));
    end
  end

  function automatic logic pickReady();
    case (readyMode)
      0: return 1'b0;
      1: return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock: drive inputs at negedge, then apply the edge outcome to the model.
  task automatic applyStimulus(input logic en, input logic s, input logic rdy,
                               input ev_e ev, input logic [W-1:0] data);
    @(negedge clk);
    bit_en  = en;
    sin     = s;
    q_ready = rdy;
    @(posedge clk);
    if (!rst_ni) begin
      expQ = '0; expValid = 1'b0; expFerr = 1'b0; expPerr = 1'b0; expOvr = 1'b0;
    end else begin
      expFerr = (ev == EV_FERR);
      expPerr = (ev == EV_PERR);
      expOvr  = (ev == EV_GOOD) && expValid && !rdy;
      if (ev == EV_GOOD) begin
        if (!expValid || rdy) begin
          expQ     = data;
          expValid = 1'b1;
        end
      end else if (expValid && rdy) begin
        expValid = 1'b0;
      end
    end
  endtask

  task automatic sendBit(input logic s, input ev_e ev, input logic [W-1:0] data, input int rdyOvr);
    repeat (3) applyStimulus(1'b0, s, pickReady(), EV_NONE, '0);
    applyStimulus(1'b1, s, (rdyOvr < 0) ? pickReady() : 1'(rdyOvr), ev, data);
  endtask

  task automatic sendFrame(input logic [W-1:0] data, input logic stopBit, input logic badPar, input int rdyOvr);
    ev_e ev;
    sendBit(1'b0, EV_NONE, '0, -1);
    for (int i = 0; i < W; i++) sendBit(data[i], EV_NONE, '0, -1);
`ifdef SIPO_FRAME_RX_PARITY_EN
    sendBit((^data) ^ badPar, EV_NONE, '0, -1);
    ev = !stopBit ? EV_FERR : (badPar ? EV_PERR : EV_GOOD);
`else
    ev = !stopBit ? EV_FERR : EV_GOOD;
`endif
    sendBit(stopBit, ev, data, rdyOvr);
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b1, 1'b1, EV_NONE, '0);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    checkEn = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, EV_NONE, '0);
    #1;
    checkOutput("reset_q", 32'(q), 32'h0);
    checkOutput("reset_valid", 32'(q_valid), 32'h0);
    checkOutput("reset_flags", {29'h0, frame_err, parity_err, overrun}, 32'h0);
    rst_ni = 1'b1;
    repeat (3) sendBit(1'b1, EV_NONE, '0, -1);

    readyMode = 0;
    sendFrame(4'b1010, 1'b1, 1'b0, -1);
    #1;
    checkOutput("pin_q_1010", 32'(q), 32'hA);
    checkOutput("pin_valid_1010", 32'(q_valid), 32'h1);
    drain();
    #1;
    checkOutput("pin_drained", 32'(q_valid), 32'h0);
    checkOutput("pin_q_hold", 32'(q), 32'hA);

    sendFrame(4'b1100, 1'b1, 1'b0, -1);
    sendFrame(4'b0011, 1'b1, 1'b0, -1);
    #1;
    checkOutput("pin_overrun", 32'(overrun), 32'h1);
    checkOutput("pin_q_kept", 32'(q), 32'hC);
    drain();
    sendFrame(4'b1100, 1'b1, 1'b0, -1);
    sendFrame(4'b0011, 1'b1, 1'b0, 1);
    #1;
    checkOutput("pin_q_replaced", 32'(q), 32'h3);
    checkOutput("pin_no_overrun", 32'(overrun), 32'h0);

    sendFrame(4'b0110, 1'b0, 1'b0, -1);
    #1;
    checkOutput("pin_frame_err", 32'(frame_err), 32'h1);
    checkOutput("pin_valid_kept", 32'(q_valid), 32'h1);
    repeat (8) sendBit(1'b0, EV_NONE, '0, -1);
    sendBit(1'b1, EV_NONE, '0, -1);
    drain();
    sendFrame(4'b0101, 1'b1, 1'b0, -1);
    #1;
    checkOutput("pin_after_break", 32'(q), 32'h5);
    drain();

`ifdef SIPO_FRAME_RX_PARITY_EN
    sendFrame(4'b0111, 1'b1, 1'b1, -1);
    #1;
    checkOutput("pin_parity_err", 32'(parity_err), 32'h1);
    checkOutput("pin_parity_drop", 32'(q_valid), 32'h0);
    sendFrame(4'b0111, 1'b1, 1'b0, -1);
    #1;
    checkOutput("pin_q_0111", 32'(q), 32'h7);
    drain();
`endif

    sendBit(1'b0, EV_NONE, '0, -1);
    sendBit(1'b1, EV_NONE, '0, -1);
    sendBit(1'b0, EV_NONE, '0, -1);
    #1 rst_ni = 1'b0;
    expQ = '0; expValid = 1'b0; expFerr = 1'b0; expPerr = 1'b0; expOvr = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, EV_NONE, '0);
    #1 rst_ni = 1'b1;
    sendBit(1'b1, EV_NONE, '0, -1);
    sendFrame(4'b1001, 1'b1, 1'b0, -1);
    #1;
    checkOutput("pin_q_1001", 32'(q), 32'h9);
    checkOutput("pin_no_err", {30'h0, frame_err, parity_err}, 32'h0);
    drain();

    readyMode = 2;
    for (int f = 0; f < 60; f++) begin
      logic [W-1:0] d;
      logic stopBit, badPar;
      d       = W'($urandom_range(0, (1 << W) - 1));
      stopBit = ($urandom_range(0, 9) != 0);
      badPar  = ($urandom_range(0, 5) == 0);
      sendFrame(d, stopBit, badPar, -1);
      if (!stopBit) begin
        repeat ($urandom_range(0, 3)) sendBit(1'b0, EV_NONE, '0, -1);
        sendBit(1'b1, EV_NONE, '0, -1);
      end else begin
        repeat ($urandom_range(0, 2)) sendBit(1'b1, EV_NONE, '0, -1);
      end
    end
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, EV_NONE, '0);

    @(negedge clk);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-in, parallel-out frame receiver: the receive end of the team's 4-bit serial register link. It detects a start bit on a one-bit line, shifts in `WIDTH` data bits LSB-first and checks the stop bit. It then presents the word on a parallel output held in a one-entry buffer with a valid/ready handshake. It sits between the link pin (already synchronised, with a bit-centred sample strobe from upstream) and any parallel register consumer.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 2..16.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `bit_en`  in  1: sample strobe; at most one bit is consumed per `clk` edge with `bit_en`=1.
- `sin`  in  1: serial line; idles high.
- `q`  out  WIDTH: received word, valid while `q_valid`=1.
- `q_valid`  out  1: holding buffer full.
- `q_ready`  in  1: consumer accepts `q` at an edge where `q_valid`=1.
- `frame_err`  out  1: one-cycle pulse; stop bit sampled 0 and the word is discarded.
- `parity_err`  out  1: one-cycle pulse; parity mismatch and the word is discarded (always 0 when parity is compiled out).
- `overrun`  out  1: one-cycle pulse; a good word was dropped because the buffer was full and not being read.

## Operation
- Frame format: start bit (0), `WIDTH` data bits LSB first, optional even-parity bit, stop bit (1).
- The FSM advances only on edges with `bit_en`=1. Edges with `bit_en`=0 leave all state unchanged except the handshake and error pulses.
- IDLE: `sin`=0 -> DATA, bit counter = 0; `sin`=1 -> stay in IDLE.
- DATA: shift `sin` into shift register bit [cnt]. When cnt = `WIDTH`-1, go to PARITY (if compiled in) or STOP; otherwise cnt+1.
- PARITY: compare `sin` with the XOR of the data bits (even parity). Record a mismatch, then go to STOP.
- STOP:
  - `sin`=1 with no parity mismatch -> deliver the word, go to IDLE.
  - `sin`=1 with a mismatch -> pulse `parity_err`, discard, go to IDLE.
  - `sin`=0 -> pulse `frame_err`, discard, go to WAIT_HIGH.
- WAIT_HIGH: stay until `sin`=1 is sampled, then go to IDLE. This stops a break (line held low) from retriggering frames.
- Deliver into an empty buffer: `q` is loaded and `q_valid` is set.
- Deliver into a full buffer with `q_ready`=1 on the same edge: the new word replaces the old one, `q_valid` stays 1, no overrun.
- Deliver into a full buffer with `q_ready`=0: the new word is dropped, the old word is kept, `overrun` pulses.
- `q_valid`=1 and `q_ready`=1 with no delivery: `q_valid` clears and `q` holds its last value.
- Errors never touch `q` or `q_valid`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM in IDLE, counter 0, shift register 0.
  - `q`=0, `q_valid`=0, `frame_err`=`parity_err`=`overrun`=0.
- Reset asserted mid-frame aborts the frame silently with no error pulse.
- Latency: `q_valid` rises on the same edge that samples a good stop bit, so it is visible in the following cycle.
- A frame takes `WIDTH`+2 strobes, or `WIDTH`+3 with parity.
- Error and overrun pulses are registered: high for exactly one `clk` cycle after the stop-sampling edge.
- Back-to-back frames are legal: a start bit may be sampled on the strobe immediately after the stop bit.
- `q_ready` while `q_valid`=0 has no effect.

## Configuration
- `SIPO_FRAME_RX_PARITY_EN` defined: the PARITY state and even-parity check are included, and a frame is `WIDTH`+3 bits.
- Not defined: the PARITY state is removed, DATA goes straight to STOP, and `parity_err` is tied to 0. The port list is identical in both builds.

## Structure
- Package `sipo_frame_rx_pkg` holds:
  - the state encoding (IDLE=0, DATA=1, PARITY=2, STOP=3, WAIT_HIGH=4, 3-bit);
  - localparams for idle level, start level and stop level;
  - an even-parity function over `WIDTH` bits.
- Sub-module `sipo_shift`: a `WIDTH`-bit shift register with enable, `sin` input and parallel output, reset to 0. The top level holds the FSM, counter, holding buffer and flags.

## Test plan
All scenarios use `WIDTH`=4 with a `bit_en` pulse every 4th `clk`.
- Reset held low, then released with `sin`=1 -> `q`=0000, `q_valid`=0, all flags 0, FSM stays in IDLE.
- Send a frame with data 1010 (serial bits 0,1,0,1) and `q_ready`=0 -> `q`=1010 and `q_valid`=1 one cycle after the stop strobe; then `q_ready`=1 for one cycle -> `q_valid`=0.
- Send 1100, then 0011 with `q_ready`=0 -> `q` stays 1100 and `overrun` pulses once. Repeat with `q_ready`=1 on the second stop edge -> `q`=0011, no overrun.
- Send a frame with data 0110 and stop bit 0 -> `frame_err` pulses, `q_valid` unchanged. Hold `sin`=0 for 8 strobes -> no new frame starts until `sin`=1 is sampled.
- Parity build: send 0111 with parity bit 0 -> `parity_err` pulses and the word is dropped. Send 0111 with parity bit 1 -> `q`=0111.
- Assert reset after 2 data strobes, release, then send 1001 -> `q`=1001 with no error pulses.
